// File: rtl/ippcrc_crc32_chk.sv
// Receive-side CRC-32 checker: strips the trailing FCS word, forwards the payload one
// word late, and reports a pass/fail per frame with saturating frame/error counters.
module ippcrc_crc32_chk #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic [31:0]      i_dat,
    output logic             o_vld,
    output logic             o_sop,
    output logic             o_eop,
    output logic [31:0]      o_dat,
    output logic             o_done,
    output logic             o_err,
    output logic             o_abort,
    output logic [CNT_W-1:0] o_frmcnt,
    output logic [CNT_W-1:0] o_errcnt
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_HOLD  = 1'b1;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // One word of CRC as 32 serial steps of an MSB-first LFSR, i_dat[0] shifted in first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        // NOTE: blocking assignments are correct here; r is a combinational temporary
        // that must see its own update on every loop iteration.
        r = c;
        for (int i = 0; i < 32; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // The FCS goes on the line bit-reversed and inverted relative to the register.
    function automatic logic [31:0] crc_fcs(input logic [31:0] c);
        logic [31:0] f;
        for (int i = 0; i < 32; i++) f[i] = ~c[31-i];
        return f;
    endfunction

    logic [0:0]  state;
    logic [31:0] hold;
    logic [31:0] crc;
    logic        first;
    logic [31:0] crc_next;
    logic        fcs_ok;

    assign crc_next = crc_step(crc, hold);
    assign fcs_ok   = (i_dat == crc_fcs(crc_next));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold     <= '0;
            crc      <= CRC_INIT;
            first    <= 1'b0;
            o_vld    <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_dat    <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_abort  <= 1'b0;
            o_frmcnt <= '0;
            o_errcnt <= '0;
        end else begin
            // NOTE: non-blocking everywhere in sequential logic so every register samples
            // the pre-edge values; the defaults below are then overridden by the case.
            o_vld   <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_abort <= 1'b0;

            if (o_done) begin
                if (o_frmcnt != '1)          o_frmcnt <= o_frmcnt + CNT_W'(1);
                if (o_err && o_errcnt != '1) o_errcnt <= o_errcnt + CNT_W'(1);
            end

            if (i_vld) begin
                case (state)
                    ST_IDLE: begin
                        if (i_sop) begin
                            if (i_eop) begin
                                o_done <= 1'b1;
                                o_err  <= 1'b1;
                            end else begin
                                hold  <= i_dat;
                                crc   <= CRC_INIT;
                                first <= 1'b1;
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (i_sop) begin
                            // A sop+eop word arriving here is absorbed into the abort report.
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                            o_abort <= 1'b1;
                            crc     <= CRC_INIT;
                            if (i_eop) begin
                                state <= ST_IDLE;
                            end else begin
                                hold  <= i_dat;
                                first <= 1'b1;
                            end
                        end else begin
                            o_vld <= 1'b1;
                            o_sop <= first;
                            o_dat <= hold;
                            first <= 1'b0;
                            if (i_eop) begin
                                o_eop  <= 1'b1;
                                o_done <= 1'b1;
                                o_err  <= ~fcs_ok;
                                crc    <= CRC_INIT;
                                state  <= ST_IDLE;
                            end else begin
                                crc  <= crc_next;
                                hold <= i_dat;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
